nbit_restoring_divider: RTL and testbench
=========================================

# nbit_restoring_divider

Multi-cycle N-bit unsigned integer divider that implements division as repeated trial subtraction, one quotient bit per clock. Sits in the arithmetic library next to the combinational add/subtract datapath and supplies the inverse operation for blocks that need quotient and remainder without a combinational divider. Operands enter on a valid/ready handshake and results leave on a second valid/ready handshake. The output is held until the consumer accepts it.

## Interface
- NBIT, 10, operand, quotient and remainder width (≥2)
- clk_i  input  1  clock; all state changes on the rising edge
- rst_i  input  1  reset, synchronous, active-high
- in_valid_i  input  1  operands valid
- in_ready_o  output  1  block can accept operands (high only in IDLE)
- dividend_i  input  NBIT  dividend, sampled on the accept edge
- divisor_i  input  NBIT  divisor, sampled on the accept edge
- out_valid_o  output  1  result valid (high only in DONE)
- out_ready_i  input  1  consumer takes result
- quotient_o  output  NBIT  quotient
- remainder_o  output  NBIT  remainder
- div_by_zero_o  output  1  divisor was zero; qualified by out_valid_o

## Operation
- FSM states and transitions:
  - IDLE: on accept (in_valid_i & in_ready_o) go to CALC; if the sampled divisor is 0, go to DONE instead.
  - CALC: runs iterations. After iteration NBIT, go to DONE.
  - DONE: on out_valid_o & out_ready_i, go to IDLE.
- On accept:
  - Capture the divisor.
  - q := dividend.
  - r := 0. r is NBIT+1 bits wide, and its MSB is the borrow.
  - Clear the iteration counter.
- Each CALC iteration:
  - Form the shifted partial remainder rs := {r[NBIT-1:0], q[NBIT-1]}.
  - Compute t := rs − {1'b0, divisor} at NBIT+1 bits.
  - If t[NBIT]==0, then r := t and q := {q[NBIT-2:0], 1}.
  - Otherwise r := rs and q := {q[NBIT-2:0], 0}.
- Result: quotient_o = q and remainder_o = r[NBIT-1:0]. The remainder is always less than the divisor.
- Divide by zero: quotient_o = all ones, remainder_o = dividend, div_by_zero_o = 1. No iterations are run.
- Inputs are ignored outside IDLE; operand changes during CALC or DONE have no effect.
- The block never accepts new operands in the same cycle a result is taken, because in_ready_o is low in DONE.
- Reset at any time, including mid-CALC, aborts the operation:
  - The next state is IDLE.
  - All datapath registers are cleared.

## Timing
- Reset values:
  - in_ready_o = 1
  - out_valid_o = 0
  - quotient_o = 0
  - remainder_o = 0
  - div_by_zero_o = 0
  - State IDLE, counter 0.
- Latency:
  - Normal divide: out_valid_o rises NBIT edges after the accepting edge.
  - Divide by zero: out_valid_o rises 1 edge after the accepting edge.
- While out_valid_o=1 and out_ready_i=0, all outputs hold stable.
- in_ready_o rises the edge after the output handshake completes.
- Minimum initiation interval is NBIT+2 cycles with out_ready_i tied high.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- DIV_SIGNED_EN:
  - Defined:
    - Operands are two's complement.
    - Magnitudes are taken at accept, and the core runs unsigned.
    - Quotient is negated when the operand signs differ.
    - Remainder takes the sign of the dividend, so division truncates toward zero.
    - Sign fix-up is applied combinationally on the DONE-state registers, so latency is unchanged.
    - −2^(NBIT−1) / −1 wraps to −2^(NBIT−1) with no flag.
    - Divide by zero gives quotient −1 (all ones) and remainder = dividend.
  - Undefined: the block is unsigned only, and no sign logic is present.

## Structure
- Package nbit_div_pkg holds:
  - the state enum typedef (IDLE, CALC, DONE);
  - the default NBIT constant;
  - the counter width, computed as $clog2(NBIT+1).
- One sub-module, div_sub_stage. It is combinational and NBIT-parameterized:
  - Inputs: rs and divisor.
  - Outputs: the next r and the quotient bit.
  - It contains the NBIT+1-bit trial subtraction and the restore mux.
- The top level holds the FSM, counter, q/r registers, handshakes and the optional sign logic.

## Test plan
All scenarios use NBIT=10.
- 1000 / 7, out_ready_i high -> after 10 edges out_valid_o=1, quotient_o=142, remainder_o=6, div_by_zero_o=0.
- 5 / 0 -> after 1 edge out_valid_o=1, quotient_o=1023, remainder_o=5, div_by_zero_o=1.
- Boundaries:
  - 3 / 9 -> q=0, r=3.
  - 1023 / 1 -> q=1023, r=0.
  - 1023 / 1023 -> q=1, r=0.
- Backpressure: hold out_ready_i low for 5 cycles after out_valid_o rises -> outputs stable, in_ready_o=0. Toggle the operand inputs in the same window -> no effect.
- Assert rst_i for one cycle during iteration 4 -> next cycle in_ready_o=1, out_valid_o=0, quotient_o=0, remainder_o=0. A subsequent 100 / 10 gives q=10, r=0.
- DIV_SIGNED_EN defined:
  - −100 / 7 -> q=1010 (−14), r=1022 (−2).
  - −512 / −1 -> q=512 (−512).

Source files
------------

// File: rtl/nbit_div_pkg.sv
// Shared types and constants for the restoring divider: FSM state encoding,
// default operand width and iteration-counter width.
package nbit_div_pkg;

    localparam int NBIT_DEFAULT = 10;
    localparam int CNT_W_DEFAULT = $clog2(NBIT_DEFAULT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    function automatic int cnt_width(input int nbit);
        return $clog2(nbit + 1);
    endfunction

endpackage

// File: rtl/div_sub_stage.sv
// One restoring-division step: trial subtraction of the divisor from the
// shifted partial remainder, keeping the difference only when it does not borrow.
module div_sub_stage #(
    parameter int NBIT = 10
) (
    input  logic [NBIT:0]   rs,
    input  logic [NBIT-1:0] divisor,
    output logic [NBIT:0]   r_next,
    output logic            q_bit
);

    logic [NBIT:0] t;

    // rs < 2*divisor, so the MSB of the NBIT+1-bit difference is an exact borrow.
    assign t      = rs - {1'b0, divisor};
    assign q_bit  = ~t[NBIT];
    assign r_next = t[NBIT] ? rs : t;

endmodule

// File: rtl/nbit_restoring_divider.sv
// Multi-cycle restoring divider, one quotient bit per clock, valid/ready on both sides.
// Optional DIV_SIGNED_EN: two's complement operands with truncation toward zero.
module nbit_restoring_divider
    import nbit_div_pkg::*;
#(
    parameter int NBIT = NBIT_DEFAULT
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [NBIT-1:0] dividend_i,
    input  logic [NBIT-1:0] divisor_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [NBIT-1:0] quotient_o,
    output logic [NBIT-1:0] remainder_o,
    output logic            div_by_zero_o
);

    localparam int CNT_W = cnt_width(NBIT);

    div_state_t      state;
    logic [CNT_W-1:0] cnt;
    logic [NBIT-1:0] q_reg;
    logic [NBIT:0]   r_reg;
    logic [NBIT-1:0] divisor_reg;
    logic            in_ready_q;
    logic            out_valid_q;
    logic            dbz_q;

    logic [NBIT:0]   rs;
    logic [NBIT:0]   r_next;
    logic            q_bit;
    logic [NBIT-1:0] dividend_mag;
    logic [NBIT-1:0] divisor_mag;
    logic            unused_r_msb;

    assign rs           = {r_reg[NBIT-1:0], q_reg[NBIT-1]};
    assign unused_r_msb = r_reg[NBIT];

    div_sub_stage #(.NBIT(NBIT)) u_sub_stage (
        .rs      (rs),
        .divisor (divisor_reg),
        .r_next  (r_next),
        .q_bit   (q_bit)
    );

`ifdef DIV_SIGNED_EN
    logic neg_q;
    logic neg_r;

    assign dividend_mag = dividend_i[NBIT-1] ? -dividend_i : dividend_i;
    assign divisor_mag  = divisor_i[NBIT-1]  ? -divisor_i  : divisor_i;

    // Divide-by-zero results bypass the sign fix-up: -1 and the raw dividend.
    assign quotient_o  = (neg_q && !dbz_q) ? -q_reg : q_reg;
    assign remainder_o = (neg_r && !dbz_q) ? -r_reg[NBIT-1:0] : r_reg[NBIT-1:0];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (state == IDLE && in_valid_i && in_ready_q) begin
            neg_q <= dividend_i[NBIT-1] ^ divisor_i[NBIT-1];
            neg_r <= dividend_i[NBIT-1];
        end
    end
`else
    assign dividend_mag = dividend_i;
    assign divisor_mag  = divisor_i;
    assign quotient_o   = q_reg;
    assign remainder_o  = r_reg[NBIT-1:0];
`endif

    assign in_ready_o    = in_ready_q;
    assign out_valid_o   = out_valid_q;
    assign div_by_zero_o = dbz_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            cnt         <= '0;
            q_reg       <= '0;
            r_reg       <= '0;
            divisor_reg <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid_i && in_ready_q) begin
                        divisor_reg <= divisor_mag;
                        cnt         <= '0;
                        in_ready_q  <= 1'b0;
                        if (divisor_i == '0) begin
                            state <= DONE;
                            q_reg <= '1;
                            r_reg <= {1'b0, dividend_i};
                            dbz_q <= 1'b1;
                        end else begin
                            state <= CALC;
                            q_reg <= dividend_mag;
                            r_reg <= '0;
                            dbz_q <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    r_reg <= r_next;
                    q_reg <= {q_reg[NBIT-2:0], q_bit};
                    cnt   <= cnt + 1'b1;
                    if (cnt == CNT_W'(NBIT - 1)) begin
                        state       <= DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    // Divide-by-zero enters DONE with valid low; it rises one edge later.
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                    end else if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state       <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nbit_restoring_divider.sv
// Scoreboard bench for nbit_restoring_divider: driver pushes expected results
// from an arithmetic reference model, a monitor pops and compares on output.
module tb_nbit_restoring_divider;

    localparam int NBIT = 10;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            in_valid_i;
    logic            in_ready_o;
    logic [NBIT-1:0] dividend_i;
    logic [NBIT-1:0] divisor_i;
    logic            out_valid_o;
    logic            out_ready_i;
    logic [NBIT-1:0] quotient_o;
    logic [NBIT-1:0] remainder_o;
    logic            div_by_zero_o;

    nbit_restoring_divider #(.NBIT(NBIT)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .in_valid_i    (in_valid_i),
        .in_ready_o    (in_ready_o),
        .dividend_i    (dividend_i),
        .divisor_i     (divisor_i),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .quotient_o    (quotient_o),
        .remainder_o   (remainder_o),
        .div_by_zero_o (div_by_zero_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [NBIT-1:0] q;
        logic [NBIT-1:0] r;
        logic            dbz;
        int              rise;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
    endtask

    // Reference: plain integer division, with the divide-by-zero convention.
    function automatic exp_t model(input logic [NBIT-1:0] a, input logic [NBIT-1:0] b, input int acc);
        exp_t e;
        if (b == '0) begin
            e.q    = '1;
            e.r    = a;
            e.dbz  = 1'b1;
            e.rise = acc + 1;
        end else begin
`ifdef DIV_SIGNED_EN
            int sa;
            int sd;
            sa    = int'($signed(a));
            sd    = int'($signed(b));
            e.q   = NBIT'(sa / sd);
            e.r   = NBIT'(sa % sd);
`else
            e.q   = a / b;
            e.r   = a % b;
`endif
            e.dbz  = 1'b0;
            e.rise = acc + NBIT;
        end
        return e;
    endfunction

    // Monitor: compare at the first valid cycle, then require stability until taken.
    initial begin : monitor
        exp_t            e;
        logic            have;
        logic            hs;
        logic [NBIT-1:0] hq;
        logic [NBIT-1:0] hr;
        logic            hd;
        have = 1'b0;
        hs   = 1'b0;
        forever begin
            @(negedge clk_i);
            #1;
            if (rst_i) begin
                have = 1'b0;
                hs   = 1'b0;
            end else if (out_valid_o) begin
                if (!have) begin
                    if (sb.size() == 0) begin
                        timeout_fail("unexpected_output");
                    end else begin
                        e = sb.pop_front();
                        chk("latency", cyc, e.rise);
                        chk("quotient", quotient_o, e.q);
                        chk("remainder", remainder_o, e.r);
                        chk("div_by_zero", div_by_zero_o, e.dbz);
                    end
                    chk("in_ready_in_done", in_ready_o, 0);
                    hq   = quotient_o;
                    hr   = remainder_o;
                    hd   = div_by_zero_o;
                    have = 1'b1;
                end else begin
                    chk("hold_quotient", quotient_o, hq);
                    chk("hold_remainder", remainder_o, hr);
                    chk("hold_dbz", div_by_zero_o, hd);
                    chk("hold_in_ready", in_ready_o, 0);
                end
                if (out_ready_i) begin
                    hs   = 1'b1;
                    have = 1'b0;
                end
            end else if (hs) begin
                chk("in_ready_after_take", in_ready_o, 1);
                hs = 1'b0;
            end
        end
    end

    task automatic run_op(input logic [NBIT-1:0] a, input logic [NBIT-1:0] b, input int hold);
        int n;
        n = 0;
        while (!in_ready_o && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        if (!in_ready_o) begin
            timeout_fail("wait_in_ready");
            return;
        end
        in_valid_i  = 1'b1;
        dividend_i  = a;
        divisor_i   = b;
        out_ready_i = (hold == 0);
        sb.push_back(model(a, b, cyc + 1));
        @(negedge clk_i);
        in_valid_i = 1'b0;
        n = 0;
        while (!out_valid_o && n < 40) begin
            dividend_i = NBIT'($urandom);
            divisor_i  = NBIT'($urandom);
            in_valid_i = 1'($urandom);
            @(negedge clk_i);
            n++;
        end
        in_valid_i = 1'b0;
        if (!out_valid_o) begin
            timeout_fail("wait_out_valid");
        end else begin
            for (int i = 0; i < hold; i++) begin
                dividend_i = NBIT'($urandom);
                divisor_i  = NBIT'($urandom);
                in_valid_i = 1'b1;
                @(negedge clk_i);
            end
            in_valid_i  = 1'b0;
            out_ready_i = 1'b1;
            @(negedge clk_i);
        end
    endtask

    initial begin : driver
        logic [NBIT-1:0] a;
        logic [NBIT-1:0] b;
        rst_i       = 1'b1;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        dividend_i  = '0;
        divisor_i   = '0;
        repeat (3) @(negedge clk_i);
        chk("rst_in_ready", in_ready_o, 1);
        chk("rst_out_valid", out_valid_o, 0);
        chk("rst_quotient", quotient_o, 0);
        chk("rst_remainder", remainder_o, 0);
        chk("rst_dbz", div_by_zero_o, 0);
        rst_i = 1'b0;
        @(negedge clk_i);

        run_op(10'd1000, 10'd7, 0);
        run_op(10'd5, 10'd0, 0);
        run_op(10'd3, 10'd9, 0);
        run_op(10'd1023, 10'd1, 0);
        run_op(10'd1023, 10'd1023, 0);
        run_op(10'd777, 10'd13, 5);
        run_op(10'd42, 10'd0, 5);

        // Abort mid-CALC: accept, then reset on the fourth iteration edge.
        in_valid_i  = 1'b1;
        dividend_i  = 10'd555;
        divisor_i   = 10'd3;
        out_ready_i = 1'b1;
        @(negedge clk_i);
        in_valid_i = 1'b0;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        chk("abort_in_ready", in_ready_o, 1);
        chk("abort_out_valid", out_valid_o, 0);
        chk("abort_quotient", quotient_o, 0);
        chk("abort_remainder", remainder_o, 0);
        chk("abort_dbz", div_by_zero_o, 0);
        run_op(10'd100, 10'd10, 0);

        run_op(10'd924, 10'd7, 0);
        run_op(10'd512, 10'd1023, 0);

        for (int i = 0; i < 40; i++) begin
            a = NBIT'($urandom);
            case ($urandom_range(0, 7))
                0:       b = '0;
                1, 2:    b = NBIT'($urandom_range(1, 15));
                default: b = NBIT'($urandom);
            endcase
            run_op(a, b, $urandom_range(0, 3));
        end

        repeat (3) @(negedge clk_i);
        chk("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
